spram_ctrl: RTL

Initiator-side controller for the team's 8-bit × 64-entry single-port RAM (write-enable, registered read address, combinational read data). Accepts host write/read requests over a valid/ready handshake, sequences the RAM port with correct read timing, and returns read data over a valid/ready response channel. An optional post-reset sweep clears every location before host traffic is admitted.

---
 rtl/spram_pkg.sv | 16 +
 rtl/spram_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/spram_pkg.sv
// Shared definitions for the 8x64 single-port RAM and its clients:
// default geometry and the controller state encoding.
package spram_pkg;

   localparam int SPRAM_DATA_W = 8;
   localparam int SPRAM_ADDR_W = 6;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_CAPT,
      ST_RSP
   } spram_state_t;

endpackage

// File: rtl/spram_ctrl.sv
// Initiator-side controller for the single-port RAM (registered read
// address, combinational read data). Host requests arrive on a valid/ready
// channel; reads are returned on a valid/ready response channel.
// Optional feature: define SPRAM_CTRL_INIT_EN to clear every RAM location
// with INIT_VALUE after reset before host traffic is admitted.
module spram_ctrl
   import spram_pkg::*;
#(
   parameter int                DATA_W     = SPRAM_DATA_W,
   parameter int                ADDR_W     = SPRAM_ADDR_W,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              init_done
);

   spram_state_t state;

`ifdef SPRAM_CTRL_INIT_EN
   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] init_cnt;
`else
   logic unused_init_value;
   assign unused_init_value = ^INIT_VALUE;
`endif

   // Controller FSM: sequences the RAM port and owns every registered output
   always_ff @(posedge clk) begin
      if (rst) begin
`ifdef SPRAM_CTRL_INIT_EN
         state    <= ST_INIT;
         init_cnt <= '0;
`else
         state    <= ST_IDLE;
`endif
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         init_done <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         unique case (state)
`ifdef SPRAM_CTRL_INIT_EN
            // The sweep ends one edge after the last write is issued, which
            // is detected from the registered port (we high on LAST_ADDR).
            ST_INIT: begin
               if (ram_we && ram_addr == LAST_ADDR) begin
                  state     <= ST_IDLE;
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
               end else begin
                  ram_we   <= 1'b1;
                  ram_addr <= init_cnt;
                  ram_data <= INIT_VALUE;
                  init_cnt <= init_cnt + 1'b1;
               end
            end
`endif
            ST_IDLE: begin
               if (!init_done) begin
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
               end else if (req_valid && req_ready) begin
                  ram_addr <= req_addr;
                  if (req_we) begin
                     ram_we   <= 1'b1;
                     ram_data <= req_wdata;
                  end else begin
                     req_ready <= 1'b0;
                     state     <= ST_RD_ISSUE;
                  end
               end
            end
            ST_RD_ISSUE: begin
               state <= ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
               rsp_rdata <= ram_dout;
               rsp_valid <= 1'b1;
               state     <= ST_RSP;
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
